mem_wr: RTL and testbench

- Frame writer that sits directly upstream of the BRAM frame-buffer read stage.
- Accepts a pixel stream aligned to start-of-frame and writes exactly BRAM_DEPTH pixels into BRAM at addresses 0..BRAM_DEPTH-1.
- On frame completion, raises a stretched request level so the read stage can double-flop it safely and begin draining the buffer.

---
 rtl/mem_wr_pkg.sv | 19 +
 rtl/mem_wr_req_stretch.sv | 44 ++++
 rtl/mem_wr.sv | 141 ++++++++++++++
 tb/tb_mem_wr.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wr_pkg.sv
// Shared definitions for the frame writer and the BRAM read stage.
// State encodings and address-width helpers live here.
package mem_wr_pkg;

    localparam int BRAM_DEPTH_DEF = 16384;
    localparam int ADDR_W = $clog2(BRAM_DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_REQ   = 2'd2
    } state_e;

    // Guards against a zero-width address bus on a one-entry buffer.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_wr_req_stretch.sv
// Counter-based pulse stretcher: one trigger cycle becomes a CYCLES-long
// registered level, wide enough for a 2-flop synchroniser to catch.
module req_stretch
    import mem_wr_pkg::*;
#(
    parameter int CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic level_o,
    output logic last_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_q;

    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = CW'(CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= (cnt_d != '0);
        end
    end

    assign level_o = lvl_q;
    // High during the final cycle of the stretched level.
    assign last_o  = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_wr.sv
// Frame writer: captures one SOF-aligned frame into BRAM addresses
// 0..BRAM_DEPTH-1, then raises a stretched request for the read stage.
module mem_wr
    import mem_wr_pkg::*;
#(
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
    parameter int DATA_WIDTH = 12,
    parameter int REQ_CYCLES = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_arm,
    input  logic                            i_valid,
    input  logic                            i_sof,
    input  logic [DATA_WIDTH-1:0]           i_data,
    output logic                            o_we,
    output logic [addr_w(BRAM_DEPTH)-1:0]   o_waddr,
    output logic [DATA_WIDTH-1:0]           o_wdata,
    output logic                            o_req,
    output logic                            o_busy,
    output logic                            o_frame_err
);

    localparam int AW = addr_w(BRAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [AW-1:0]           waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    fire_q, fire_d;
    logic [AW-1:0]           addr_nx;
    logic                    start;
    logic                    req_lvl;
    logic                    req_last;

    assign addr_nx = waddr_q + AW'(1);
    assign start   = i_valid & i_sof & i_arm;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        fire_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = i_data;
                    if (LAST_ADDR == '0) begin
                        state_d = ST_REQ;
                        fire_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // A premature SOF aborts the frame, even on its last pixel.
                if (i_valid && i_sof) begin
                    err_d = 1'b1;
                    if (i_arm) begin
                        we_d    = 1'b1;
                        waddr_d = '0;
                        wdata_d = i_data;
                        if (LAST_ADDR == '0) begin
                            state_d = ST_REQ;
                            fire_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (i_valid) begin
                    we_d    = 1'b1;
                    waddr_d = addr_nx;
                    wdata_d = i_data;
                    if (addr_nx == LAST_ADDR) begin
                        state_d = ST_REQ;
                        fire_d  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (req_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            fire_q  <= fire_d;
        end
    end

    // Triggered the cycle the final write is presented, so the request
    // level follows it by one cycle.
    req_stretch #(
        .CYCLES (REQ_CYCLES)
    ) u_req_stretch (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .trig_i  (fire_q),
        .level_o (req_lvl),
        .last_o  (req_last)
    );

    assign o_we        = we_q;
    assign o_waddr     = waddr_q;
    assign o_wdata     = wdata_q;
    assign o_req       = req_lvl;
    assign o_busy      = busy_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_mem_wr.sv
// Self-checking bench for mem_wr against a cycle-level behavioural model.
// Small frame (16 pixels, 8-bit data, 4-cycle request).
module tb_mem_wr;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int RC    = 4;
    localparam int AW    = 4;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          arm   = 1'b0;
    logic          valid = 1'b0;
    logic          sof   = 1'b0;
    logic [DW-1:0] data  = '0;

    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic          o_req;
    logic          o_busy;
    logic          o_frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wr #(
        .BRAM_DEPTH (DEPTH),
        .DATA_WIDTH (DW),
        .REQ_CYCLES (RC)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_arm       (arm),
        .i_valid     (valid),
        .i_sof       (sof),
        .i_data      (data),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_req       (o_req),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
    );

    // Model: mode 0 = waiting for SOF, 1 = filling, 2 = after last pixel.
    int            m_mode;
    int            m_cnt;
    int            m_after;
    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_req;
    logic          e_busy;
    logic          e_err;

    function automatic void model_reset();
        m_mode  = 0;
        m_cnt   = 0;
        m_after = 0;
        e_we    = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
        e_req   = 1'b0;
        e_busy  = 1'b0;
        e_err   = 1'b0;
    endfunction

    function automatic void emit(input int idx);
        e_we    = 1'b1;
        e_waddr = AW'(idx);
        e_wdata = data;
        m_cnt   = idx + 1;
        if (m_cnt == DEPTH) begin
            m_mode  = 2;
            m_after = 1;
        end else begin
            m_mode = 1;
        end
    endfunction

    function automatic void model_edge();
        e_we  = 1'b0;
        e_err = 1'b0;
        e_req = 1'b0;
        case (m_mode)
            0: if (arm && valid && sof) emit(0);
            1: if (valid) begin
                if (sof) begin
                    e_err = 1'b1;
                    if (arm) emit(0);
                    else m_mode = 0;
                end else begin
                    emit(m_cnt);
                end
            end
            default: begin
                m_after++;
                if (m_after > RC + 1) m_mode = 0;
                else e_req = (m_after >= 2);
            end
        endcase
        e_busy = (m_mode != 0);
    endfunction

    function automatic logic [15:0] obs_vec();
        return {o_we, o_we ? o_waddr : 4'h0, o_we ? o_wdata : 8'h00,
                o_req, o_busy, o_frame_err};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {e_we, e_we ? e_waddr : 4'h0, e_we ? e_wdata : 8'h00,
                e_req, e_busy, e_err};
    endfunction

    task automatic step(input logic v, input logic s, input logic a,
                        input logic [DW-1:0] d);
        valid = v;
        sof   = s;
        arm   = a;
        data  = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        arm = 1'b1; valid = 1'b1; sof = 1'b1; data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec() !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", obs_vec(), 16'h0);
        end
        valid = 1'b0; sof = 1'b0; arm = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_contig();
        int nreq = 0;
        int nwe  = 0;
        int nerr = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (i < DEPTH) step(1'b1, i == 0, 1'b1, DW'(i));
            else step(1'b0, 1'b0, 1'b1, 8'h00);
            nreq += int'(o_req);
            nwe  += int'(o_we);
            nerr += int'(o_frame_err);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL contig c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (nreq !== RC || nwe !== DEPTH || nerr !== 0) begin
            n_bad++;
            $display("FAIL contig_counts: got req=%0d we=%0d err=%0d want %0d/%0d/0",
                     nreq, nwe, nerr, RC, DEPTH);
        end
    endtask

    task automatic test_gaps();
        int p = 0;
        int c = 0;
        int nreq = 0;
        logic [AW-1:0] last_a = '0;
        while (p < DEPTH || c < 2 * DEPTH + 8) begin
            if (p < DEPTH && (c % 2) == 0) begin
                step(1'b1, p == 0, 1'b1, DW'($urandom));
                p++;
            end else begin
                step(1'b0, 1'b0, 1'b1, DW'($urandom));
            end
            if (o_we) last_a = o_waddr;
            nreq += int'(o_req);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL gaps c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            c++;
        end
        n_cmp++;
        if (last_a !== 4'd15 || nreq !== RC) begin
            n_bad++;
            $display("FAIL gaps_end: got addr=%0d req=%0d want 15/%0d", last_a, nreq, RC);
        end
    endtask

    task automatic test_premature();
        int nreq = 0;
        int nerr = 0;
        for (int i = 0; i < 8 + DEPTH + 8; i++) begin
            if (i < 8 + DEPTH) step(1'b1, i == 0 || i == 8, 1'b1, DW'($urandom));
            else step(1'b0, 1'b0, 1'b1, 8'h00);
            nreq += int'(o_req);
            nerr += int'(o_frame_err);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL premature c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (nreq !== RC || nerr !== 1) begin
            n_bad++;
            $display("FAIL premature_counts: got req=%0d err=%0d want %0d/1", nreq, nerr, RC);
        end
    endtask

    task automatic test_sof_last();
        int nreq = 0;
        int nerr = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (i < DEPTH - 1) step(1'b1, i == 0, 1'b1, DW'($urandom));
            else if (i == DEPTH - 1) step(1'b1, 1'b1, 1'b0, 8'hEE);
            else step(1'b0, 1'b0, 1'b0, 8'h00);
            nreq += int'(o_req);
            nerr += int'(o_frame_err);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL sof_last c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (nreq !== 0 || nerr !== 1) begin
            n_bad++;
            $display("FAIL sof_last_counts: got req=%0d err=%0d want 0/1", nreq, nerr);
        end
    endtask

    task automatic test_unarmed();
        int nact = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 8) == 0, 1'b0, DW'($urandom));
            nact += int'(o_we) + int'(o_req) + int'(o_busy);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL unarmed c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (nact !== 0) begin
            n_bad++;
            $display("FAIL unarmed_activity: got %0d want 0", nact);
        end
    endtask

    task automatic test_back_to_back();
        int nreq = 0;
        int nwe  = 0;
        for (int i = 0; i < 2 * DEPTH + 5 + 8; i++) begin
            if (i < DEPTH) step(1'b1, i == 0, 1'b1, DW'($urandom));
            else if (i < DEPTH + 5) step(1'b1, 1'b1, 1'b1, DW'($urandom));
            else if (i < 2 * DEPTH + 5) step(1'b1, i == DEPTH + 5, 1'b1, DW'($urandom));
            else step(1'b0, 1'b0, 1'b1, 8'h00);
            nreq += int'(o_req);
            nwe  += int'(o_we);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (nreq !== 2 * RC || nwe !== 2 * DEPTH) begin
            n_bad++;
            $display("FAIL b2b_counts: got req=%0d we=%0d want %0d/%0d",
                     nreq, nwe, 2 * RC, 2 * DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        int nreq = 0;
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 1'b1, DW'($urandom));
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({o_we, o_req, o_busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid_async: got we/req/busy=%b want 000",
                     {o_we, o_req, o_busy});
        end
        model_reset();
        valid = 1'b0; sof = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6 + DEPTH + 8; i++) begin
            if (i < 6) step(1'b1, 1'b0, 1'b1, DW'($urandom));
            else if (i < 6 + DEPTH) step(1'b1, i == 6, 1'b1, DW'($urandom));
            else step(1'b0, 1'b0, 1'b1, 8'h00);
            if (i < 6) nreq += int'(o_req);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (nreq !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_req: got %0d want 0", nreq);
        end
    endtask

    task automatic test_random();
        logic v;
        for (int i = 0; i < 800; i++) begin
            v = ($urandom % 4) != 0;
            step(v, v && (($urandom % 30) == 0), ($urandom % 5) != 0, DW'($urandom));
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_contig();
        test_gaps();
        test_premature();
        test_sof_last();
        test_unarmed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
